// File: rtl/hit_serializer.sv
// Hit serializer: queues per-target hit edges and replays each as a one-hot pulse on des.
// Latency: a hit edge sampled at edge k is pending at edge k; des goes one-hot at edge k+1 when idle.
// No backpressure: every event takes PULSE+GAP+1 cycles; a repeat hit on a pending target is merged and flags overflow.
module hit_serializer #(
  parameter int N_TARGETS    = 10,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [N_TARGETS-1:0] hit,
  output logic [N_TARGETS-1:0] des,
  output logic                 busy,
  output logic [3:0]           pending_count,
  output logic                 overflow
);

  localparam int MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  // cnt only ever holds values up to MAX_CYC-1
  localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  logic [N_TARGETS-1:0] hit_q;
  logic [N_TARGETS-1:0] pending_q, pending_d;
  logic [N_TARGETS-1:0] sel_q, sel_d;
  logic [N_TARGETS-1:0] des_q, des_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  state_t               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 overflow_q, overflow_d;

  logic [N_TARGETS-1:0] new_hits;
  logic [N_TARGETS-1:0] lowest;
  logic [N_TARGETS-1:0] take;
  logic [3:0]           pend_cnt;

  // Edge detect, lowest-index pick and pending-set update; a bit taken and re-hit in the same cycle stays queued
  always_comb begin
    new_hits   = hit & ~hit_q & {N_TARGETS{enable}};
    lowest     = pending_q & (~pending_q + N_TARGETS'(1));
    take       = ((state_q == IDLE) && (pending_q != '0)) ? lowest : '0;
    pending_d  = (pending_q & ~take) | new_hits;
    overflow_d = overflow_q | ((new_hits & pending_q & ~take) != '0);
  end

  // Next-state logic for the pulse/gap sequencer; des is registered from des_d
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    des_d   = des_q;
    case (state_q)
      IDLE: begin
        if (pending_q != '0) begin
          sel_d   = take;
          des_d   = take;
          cnt_d   = PULSE_LOAD;
          state_d = PULSE;
        end else begin
          des_d = '0;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          des_d   = '0;
          cnt_d   = GAP_LOAD;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          des_d = sel_q;
        end
      end
      GAP: begin
        des_d = '0;
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        des_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE) || (pending_d != '0);
  end

  // Population count of the pending set for status reporting
  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < N_TARGETS; i++) begin
      pend_cnt = pend_cnt + 4'(pending_q[i]);
    end
  end

  // State registers; reset discards queued hits and drops des immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q      <= '0;
      pending_q  <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      des_q      <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      hit_q      <= hit;
      pending_q  <= pending_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      des_q      <= des_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign des           = des_q;
  assign busy          = busy_q;
  assign overflow      = overflow_q;
  assign pending_count = pend_cnt;

endmodule

// File: tb/tb_hit_serializer.sv
// Testbench for hit_serializer: directed hit patterns, expected pulse order in a scoreboard queue,
// a negedge monitor that pops and compares every des pulse plus pulse length and gap length,
// and inline checks of pending_count, busy, overflow and reset behaviour.
module tb_hit_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [9:0] hit = '0;
  logic [9:0] des;
  logic       busy;
  logic [3:0] pending_count;
  logic       overflow;

  int n_chk = 0;
  int n_err = 0;

  logic [9:0] sbq[$];

  hit_serializer #(
    .N_TARGETS(10),
    .PULSE_CYCLES(2),
    .GAP_CYCLES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .hit(hit),
    .des(des),
    .busy(busy),
    .pending_count(pending_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares each des pulse against the scoreboard, plus pulse width and zero gap
  logic [9:0] prev_des = '0;
  int         plen = 0;
  int         zeros = 100;

  always @(negedge clk) begin
    if (reset) begin
      prev_des = '0;
      plen     = 0;
      zeros    = 100;
    end else begin
      if (des != '0) begin
        if (prev_des == '0) begin
          check("gap_ge_3", 32'(zeros >= 3), 32'd1);
          check("des_onehot", 32'($onehot(des)), 32'd1);
          if (sbq.size() == 0) begin
            check("unexpected_pulse", 32'(des), 32'd0);
          end else begin
            check("pulse_value", 32'(des), 32'(sbq.pop_front()));
          end
          plen = 1;
        end else begin
          check("pulse_stable", 32'(des), 32'(prev_des));
          plen++;
        end
        zeros = 0;
      end else begin
        if (prev_des != '0) check("pulse_len", 32'(plen), 32'd2);
        if (zeros < 100) zeros++;
      end
      prev_des = des;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hit   = '0;
    sbq.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      tick();
      if (!busy && des == '0 && sbq.size() == 0) break;
    end
    if (i == budget) check("drain_timeout_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_des", 32'(des), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pcnt", 32'(pending_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    reset  = 1'b0;
    enable = 1'b1;
    tick();

    // 1: single hit on bit 2, latency and pulse timing
    hit = 10'h004;
    sbq.push_back(10'h004);
    tick();  // E0
    check("t1_pcnt_e0", 32'(pending_count), 32'd1);
    check("t1_des_e0", 32'(des), 32'd0);
    check("t1_busy_e0", 32'(busy), 32'd1);
    hit = '0;
    tick();  // E1
    check("t1_des_e1", 32'(des), 32'h004);
    check("t1_pcnt_e1", 32'(pending_count), 32'd0);
    tick();  // E2
    check("t1_des_e2", 32'(des), 32'h004);
    tick();  // E3
    check("t1_des_e3", 32'(des), 32'd0);
    tick();  // E4
    check("t1_busy_e4", 32'(busy), 32'd1);
    tick();  // E5
    check("t1_busy_e5", 32'(busy), 32'd0);
    check("t1_ovf", 32'(overflow), 32'd0);
    tick();

    // 2: three simultaneous hits, ascending service order
    hit = 10'h211;
    sbq.push_back(10'h001);
    sbq.push_back(10'h010);
    sbq.push_back(10'h200);
    tick();  // E0
    check("t2_pcnt_e0", 32'(pending_count), 32'd3);
    hit = '0;
    tick();  // E1
    check("t2_pcnt_e1", 32'(pending_count), 32'd2);
    check("t2_des_e1", 32'(des), 32'h001);
    repeat (5) tick();  // E6
    check("t2_pcnt_e6", 32'(pending_count), 32'd1);
    check("t2_des_e6", 32'(des), 32'h010);
    repeat (5) tick();  // E11
    check("t2_pcnt_e11", 32'(pending_count), 32'd0);
    check("t2_des_e11", 32'(des), 32'h200);
    wait_idle(50);
    check("t2_ovf", 32'(overflow), 32'd0);

    // 3: bit 5 re-hit while still queued behind bit 0
    hit = 10'h021;
    sbq.push_back(10'h001);
    sbq.push_back(10'h020);
    tick();  // E0
    hit = '0;
    tick();  // E1
    check("t3_ovf_e1", 32'(overflow), 32'd0);
    hit = 10'h020;
    tick();  // E2
    check("t3_ovf_e2", 32'(overflow), 32'd1);
    check("t3_pcnt_e2", 32'(pending_count), 32'd1);
    hit = '0;
    wait_idle(50);
    check("t3_ovf_sticky", 32'(overflow), 32'd1);

    // 4: bit 3 re-hit in the exact cycle it is taken
    do_reset();
    check("t4_ovf_cleared", 32'(overflow), 32'd0);
    hit = 10'h009;
    sbq.push_back(10'h001);
    sbq.push_back(10'h008);
    sbq.push_back(10'h008);
    tick();  // E0
    hit = '0;
    repeat (5) tick();  // E5
    hit = 10'h008;
    tick();  // E6: bit 3 taken and re-queued
    check("t4_des_e6", 32'(des), 32'h008);
    check("t4_pcnt_e6", 32'(pending_count), 32'd1);
    check("t4_ovf_e6", 32'(overflow), 32'd0);
    hit = '0;
    wait_idle(50);
    check("t4_ovf_end", 32'(overflow), 32'd0);

    // 5: all targets held, then enable low with hit toggling
    hit = 10'h3FF;
    for (int i = 0; i < 10; i++) sbq.push_back(10'(1 << i));
    tick();
    check("t5_pcnt", 32'(pending_count), 32'd10);
    repeat (19) tick();
    enable = 1'b0;
    for (int i = 0; i < 40; i++) begin
      hit = (i % 2 == 0) ? 10'h000 : 10'h3FF;
      tick();
    end
    hit = '0;
    wait_idle(100);
    check("t5_pcnt_end", 32'(pending_count), 32'd0);
    check("t5_sb_empty", 32'(sbq.size()), 32'd0);
    enable = 1'b1;
    tick();

    // 6: asynchronous reset in the middle of a pulse
    do_reset();
    hit = 10'h003;
    tick();  // E0
    hit = '0;
    @(posedge clk);  // E1
    #2;
    check("t6_des_before", 32'(des), 32'h001);
    reset = 1'b1;
    #1;
    check("t6_des_async", 32'(des), 32'd0);
    check("t6_busy_async", 32'(busy), 32'd0);
    check("t6_pcnt_async", 32'(pending_count), 32'd0);
    sbq.delete();
    tick();
    reset = 1'b0;
    repeat (20) tick();
    check("t6_busy_after", 32'(busy), 32'd0);
    check("t6_des_after", 32'(des), 32'd0);

    check("sb_empty_final", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hit_serializer.md
Name: hit_serializer

Overview:
- Sits directly upstream of the score display counter and drives its 10-bit `des` input.
- Collision logic can assert hit strobes on several of the 10 targets in the same cycle. The display counter advances once per zero-to-nonzero transition of `des`, so simultaneous hits would be counted once.
- This block queues every hit and replays each one as a separate one-hot pulse on `des`, with a zero gap between pulses. The downstream counter therefore sees exactly one rising event per destroyed target.

Parameters:
- N_TARGETS, 10, width of `hit` and `des`; fixed at 10 to match the downstream input.
- PULSE_CYCLES, 2, number of cycles `des` stays one-hot per event; must be ≥1.
- GAP_CYCLES, 2, number of cycles `des` stays all-zero after each pulse; must be ≥1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  game-running qualifier; when low, new hits are ignored.
- hit  in  10  per-target hit level or strobe; bit i rising counts as one hit on target i.
- des  out  10  registered; one-hot during PULSE, 0 otherwise.
- busy  out  1  registered; high while state != IDLE or pending != 0.
- pending_count  out  4  popcount of the pending register, 0..10; combinational from registers.
- overflow  out  1  sticky; set when a hit arrives on a target that is already pending.

Behaviour:
- Registers: hit_q[9:0], pending[9:0], state{IDLE,PULSE,GAP}, cnt (wide enough for max(PULSE_CYCLES,GAP_CYCLES)), sel[9:0] (one-hot), des, busy, overflow.
- Reset (async, immediate):
  - hit_q=0, pending=0, state=IDLE, cnt=0, sel=0.
  - des=0, busy=0, overflow=0.
  - Reset mid-pulse drops `des` to 0 at once; all queued hits are discarded.
- Edge detect, every cycle:
  - new = hit & ~hit_q & {10{enable}}.
  - hit_q <= hit, always, independent of enable.
  - A bit held high across reset release counts as one edge if enable=1.
- Pending update:
  - pending_next = (pending & ~take) | new.
  - take = one-hot of the lowest set bit of pending when state=IDLE and pending!=0; otherwise 0.
  - If the same bit is taken and newly hit in one cycle, set wins: the bit is re-queued and no overflow is flagged.
- Overflow:
  - Set when (new & pending & ~take) != 0.
  - The duplicate hit is merged, i.e. lost.
  - Cleared only by reset.
- FSM:
  - IDLE: if pending!=0, then sel<=take, des<=take, cnt<=PULSE_CYCLES-1, go to PULSE. Otherwise des<=0.
  - PULSE: if cnt==0, then des<=0, cnt<=GAP_CYCLES-1, go to GAP. Otherwise cnt<=cnt-1 and des holds sel.
  - GAP: if cnt==0, go to IDLE. Otherwise cnt<=cnt-1. des=0 throughout.
- Priority: lowest index first. Service order among simultaneous hits is ascending bit index.
- Latency:
  - Hit edge sampled at clock edge k sets pending at edge k.
  - des goes one-hot at edge k+1 if the FSM was IDLE.
  - Per-event period is PULSE_CYCLES+GAP_CYCLES+1 cycles (IDLE takes one cycle).
- enable low:
  - New edges are dropped.
  - Pending and in-flight events still drain.
  - des is not gated.
- busy registered = (state_next != IDLE) | (pending_next != 0).

Test Plan:
1. Reset, enable=1, hit=10'b0000000100 for 1 cycle -> des=10'b0000000100 for 2 cycles starting 1 cycle after the pending set, then 0. pending_count goes 1→0. busy falls after the gap. overflow=0.
2. hit=10'b1000010001 in a single cycle -> des pulses 0x001, 0x010, 0x200 in that order. Each pulse is 2 cycles with ≥3 zero cycles between pulses. pending_count reads 3,2,1,0 at successive IDLE exits.
3. hit bit 5 pulsed, released, and pulsed again while bit 5 is still pending (queued behind bit 0) -> overflow=1. Only one 0x020 pulse is emitted.
4. Bit 3 re-hit in the exact cycle it is taken from pending -> two 0x008 pulses. overflow stays 0.
5. hit held at 0x3FF for 20 cycles -> exactly 10 pulses, no repeats. Assert enable=0 with hit toggling -> no new pulses, and the in-flight queue completes.
6. Assert reset asynchronously mid-PULSE -> des=0 and busy=0 before the next clk edge. After release with hit=0, no pulses appear.
